// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths and player state encoding for the note player
package note_player_pkg;
   localparam int NOTE_W_DEF     = 6;
   localparam int DUR_W_DEF      = 6;
   localparam int AMP_W_DEF      = 3;
   localparam int FIFO_DEPTH_DEF = 2;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      FINISH  = 2'd2
   } player_state_t;
endpackage

// File: rtl/note_player_fifo.sv
// note_fifo: small circular queue of packed note records, head visible without a pop
module note_fifo #(
   parameter int W = 15,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   // pointer and occupancy bookkeeping; a push while full is dropped even if a pop frees a slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? inc(wr_ptr) : wr_ptr;
         rd_ptr <= do_pop ? inc(rd_ptr) : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   // storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/note_player.sv
// note_player: queues notes from the song reader and plays each for its beat count
module note_player
   import note_player_pkg::*;
#(
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int DUR_W = DUR_W_DEF,
   parameter int AMP_W = AMP_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              load_new_note,
   input  logic [NOTE_W-1:0] note_to_load,
   input  logic [DUR_W-1:0]  duration_to_load,
   input  logic [AMP_W-1:0]  amplitude_to_load,
   input  logic              beat,
   output logic              load_ready,
   output logic              new_note,
   output logic [NOTE_W-1:0] note_out,
   output logic [DUR_W-1:0]  duration_out,
   output logic [AMP_W-1:0]  amplitude_out,
   output logic              note_done,
   output logic              busy
);
   localparam int FW = NOTE_W + DUR_W + AMP_W;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   player_state_t     state, next_state;
   logic              pop, fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [FW-1:0]     head;
   logic [NOTE_W-1:0] head_note;
   logic [DUR_W-1:0]  head_dur;
   logic [AMP_W-1:0]  head_amp;
   logic [DUR_W-1:0]  remaining;
   assign {head_note, head_dur, head_amp} = head;
   assign load_ready = fifo_count < CW'(FIFO_DEPTH);
   note_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (load_new_note && !fifo_full),
      .pop   (pop),
      .din   ({note_to_load, duration_to_load, amplitude_to_load}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   // player state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= next_state;
   end
   // next state: pause freezes PLAYING; a zero-length note finishes without a beat
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    next_state = (!fifo_empty && play_enable) ? PLAYING : IDLE;
         PLAYING: next_state = (play_enable && (remaining == '0 || (beat && remaining == DUR_W'(1)))) ? FINISH : PLAYING;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end
   // pop the head only when idle and playback is enabled
   always_comb begin
      pop = (state == IDLE) && !fifo_empty && play_enable;
   end
   // registered outputs and beat countdown; rests are timed but silent
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         new_note      <= 1'b0;
         note_done     <= 1'b0;
         busy          <= 1'b0;
         note_out      <= '0;
         duration_out  <= '0;
         amplitude_out <= '0;
         remaining     <= '0;
      end else begin
         new_note  <= pop;
         note_done <= next_state == FINISH;
         busy      <= next_state != IDLE;
         if (pop) begin
            note_out      <= head_note;
            duration_out  <= head_dur;
            amplitude_out <= (head_note == '0) ? '0 : head_amp;
            remaining     <= head_dur;
         end else if (state == PLAYING && play_enable && beat && remaining != '0) begin
            remaining <= remaining - DUR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed stimulus with a scoreboard monitor checking note order, data and beat timing
module tb_note_player;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int AW = 3;
   typedef struct packed {
      logic [NW-1:0] n;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
   } note_t;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          play_enable = 1'b0;
   logic          load_new_note = 1'b0;
   logic [NW-1:0] note_to_load = '0;
   logic [DW-1:0] duration_to_load = '0;
   logic [AW-1:0] amplitude_to_load = '0;
   logic          beat = 1'b0;
   logic          load_ready, new_note, note_done, busy;
   logic [NW-1:0] note_out;
   logic [DW-1:0] duration_out;
   logic [AW-1:0] amplitude_out;
   note_t exp_q[$];
   note_t mon_e;
   int    checks = 0;
   int    failures = 0;
   int    bcnt = 0;
   int    cyc = 0;
   int    start_cyc = 0;
   int    last_beat = 0;
   int    last_done = 0;
   int    beats = 0;
   int    stray = 0;
   logic  active = 1'b0;
   logic  b2b = 1'b0;
   logic [DW-1:0] cur_dur = '0;

   note_player dut (
      .clk               (clk),
      .reset             (reset),
      .play_enable       (play_enable),
      .load_new_note     (load_new_note),
      .note_to_load      (note_to_load),
      .duration_to_load  (duration_to_load),
      .amplitude_to_load (amplitude_to_load),
      .beat              (beat),
      .load_ready        (load_ready),
      .new_note          (new_note),
      .note_out          (note_out),
      .duration_out      (duration_out),
      .amplitude_out     (amplitude_out),
      .note_done         (note_done),
      .busy              (busy)
   );

   initial forever #5 clk = ~clk;

   // one-cycle beat strobe every 6 cycles
   initial forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt == 5) ? 0 : bcnt + 1;
      beat = (bcnt == 0);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on each new_note and times note_done against enabled beats
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
         active = 1'b0;
         b2b = 1'b0;
      end else begin
         if (new_note) begin
            if (exp_q.size() == 0) check("unexpected_new_note", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               check("note_out", int'(note_out), int'(mon_e.n));
               check("duration_out", int'(duration_out), int'(mon_e.d));
               check("amplitude_out", int'(amplitude_out), int'(mon_e.a));
               if (b2b) check("b2b_gap", cyc - last_done, 2);
               b2b = 1'b0;
               active = 1'b1;
               start_cyc = cyc;
               beats = 0;
               cur_dur = mon_e.d;
            end
         end
         if (note_done) begin
            if (!active) check("spurious_note_done", 1, 0);
            else if (cur_dur == '0) check("dur0_done_gap", cyc - start_cyc, 1);
            else begin
               check("beats_at_done", beats, int'(cur_dur));
               check("done_after_beat", cyc - last_beat, 1);
            end
            active = 1'b0;
            last_done = cyc;
            b2b = (exp_q.size() != 0) && play_enable;
         end else if (active && beat && play_enable) begin
            beats++;
            last_beat = cyc;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int n, input int d, input int a, input logic acc);
      note_t e;
      load_new_note = 1'b1;
      note_to_load = NW'(n);
      duration_to_load = DW'(d);
      amplitude_to_load = AW'(a);
      @(negedge clk);
      check("load_ready_at_push", int'(load_ready), int'(acc));
      if (acc) begin
         e.n = NW'(n);
         e.d = DW'(d);
         e.a = (n == 0) ? '0 : AW'(a);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      load_new_note = 1'b0;
   endtask

   task automatic wait_new_note(input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!new_note && n < max);
      check("new_note_seen", int'(new_note), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_note_done(input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!note_done && n < max);
      check("note_done_seen", int'(note_done), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      play_enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_note_out", int'(note_out), 0);
      check("rst_duration_out", int'(duration_out), 0);
      check("rst_amplitude_out", int'(amplitude_out), 0);
      check("rst_new_note", int'(new_note), 0);
      check("rst_note_done", int'(note_done), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("load_ready_after_reset", int'(load_ready), 1);
      check("busy_after_reset", int'(busy), 0);
      cycles(1);
      // single note while idle
      push(12, 3, 4, 1'b1);
      wait_new_note(20);
      wait_note_done(60);
      // three pushes while a note plays: the third finds the queue full
      push(30, 2, 5, 1'b1);
      wait_new_note(20);
      push(31, 1, 6, 1'b1);
      push(32, 2, 1, 1'b1);
      push(33, 1, 2, 1'b0);
      wait_note_done(60);
      wait_note_done(60);
      wait_note_done(60);
      @(negedge clk);
      check("load_ready_drained", int'(load_ready), 1);
      cycles(1);
      // zero-length note
      push(5, 0, 2, 1'b1);
      wait_new_note(20);
      wait_note_done(5);
      // pause mid-note across several beats
      push(20, 5, 3, 1'b1);
      wait_new_note(20);
      cycles(4);
      play_enable = 1'b0;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (note_done || !busy) stray++;
      end
      check("pause_no_progress", stray, 0);
      check("pause_note_held", int'(note_out), 20);
      check("pause_dur_held", int'(duration_out), 5);
      check("pause_amp_held", int'(amplitude_out), 3);
      @(posedge clk);
      #1;
      play_enable = 1'b1;
      wait_note_done(60);
      // rest note is silent but timed
      push(0, 2, 7, 1'b1);
      wait_new_note(20);
      @(negedge clk);
      check("rest_amplitude", int'(amplitude_out), 0);
      wait_note_done(40);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      cycles(1);
      // reset mid-note with one queued note
      push(40, 6, 6, 1'b1);
      wait_new_note(20);
      push(41, 2, 1, 1'b1);
      cycles(3);
      reset = 1'b0;
      #1;
      check("mid_rst_note_out", int'(note_out), 0);
      check("mid_rst_duration_out", int'(duration_out), 0);
      check("mid_rst_amplitude_out", int'(amplitude_out), 0);
      check("mid_rst_new_note", int'(new_note), 0);
      check("mid_rst_note_done", int'(note_done), 0);
      check("mid_rst_busy", int'(busy), 0);
      exp_q.delete();
      cycles(2);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_load_ready", int'(load_ready), 1);
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (new_note || note_done || busy) stray++;
      end
      check("post_rst_quiet", stray, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
